// File: rtl/uart_rx_deser.sv
// UART receive deserializer: synchronizes rx_i, samples mid-bit LSB first,
// checks the stop bit and hands good bytes to a valid/ready holding register.
module uart_rx_deser #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                state, state_d;
    logic                  s1, rx_sync;
    logic [CNT_W-1:0]      clk_cnt, clk_cnt_d;
    logic [IDX_W-1:0]      bit_idx, bit_idx_d;
    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic                  good_frame, bad_frame;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1      <= 1'b1;
            rx_sync <= 1'b1;
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            s1      <= rx_i;
            rx_sync <= s1;
            state   <= state_d;
            clk_cnt <= clk_cnt_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
        end
    end

    always_comb begin
        state_d    = state;
        clk_cnt_d  = clk_cnt;
        bit_idx_d  = bit_idx;
        shreg_d    = shreg;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shreg_d   = DATA_WIDTH'({rx_sync, shreg} >> 1);
                    if (bit_idx == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_sync) begin
                        good_frame = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        bad_frame = 1'b1;
                        state_d   = BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt + 1'b1;
                end
            end
            BREAK: begin
                // a line held low must go high before a new start is accepted
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_o      <= '0;
            valid_out   <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= bad_frame;
            overrun_o   <= 1'b0;
            // a pop in the same cycle frees the register for the new byte
            if (good_frame) begin
                if (!valid_out || ready_out) begin
                    data_o    <= shreg;
                    valid_out <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_out && ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- UART receive deserializer for the UART_APB receive path; sits directly upstream of the RX byte FIFO.
- Synchronizes the asynchronous serial line and detects/validates the start bit.
- Samples data bits mid-bit, LSB first, and checks the stop bit.
- Presents each good byte on a valid/ready output whose valid_out/ready_out connect to the FIFO's valid_in/ready_in.
- Reports framing errors and overruns as one-cycle pulses.

Parameters:
- DATA_WIDTH, 8, data bits per frame (1 start, DATA_WIDTH data, 1 stop; no parity).
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range >= 4. Half-bit H = CLKS_PER_BIT/2, integer division.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  synchronous active-low reset.
- rx_i  input  1  asynchronous serial line; idle high.
- data_o  output  DATA_WIDTH  received byte; valid while valid_out=1.
- valid_out  output  1  byte available.
- ready_out  input  1  consumer accepts; transfer when valid_out & ready_out.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: good byte dropped because the holding register was full.
- busy_o  output  1  high whenever the FSM is not in IDLE.

Interface decision (already decided): one clock, clk; reset rstn is synchronous and active-low.

Behaviour:

Reset:
- Takes effect on a clk edge with rstn=0.
- Sync flops = 1, FSM = IDLE, counters = 0, shift register = 0.
- data_o = 0, valid_out = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0.
- Reset mid-frame abandons the frame without producing error pulses.

Synchronizer:
- Two flops: rx_i -> s1 -> rx_sync.
- Only rx_sync is used internally.

Counters:
- clk_cnt wide enough for CLKS_PER_BIT-1; bit_idx wide enough for DATA_WIDTH-1.

FSM:
- IDLE: rx_sync=0 -> START with clk_cnt=0.
- START: count to H-1, then sample. rx_sync=0 -> DATA with clk_cnt=0, bit_idx=0. rx_sync=1 -> glitch, return to IDLE with no flags.
- DATA: count to CLKS_PER_BIT-1, then sample. Shift rx_sync in at the MSB, shifting right (LSB first on the wire). Then clk_cnt=0. After bit_idx=DATA_WIDTH-1 -> STOP, else bit_idx+1.
- STOP: count to CLKS_PER_BIT-1, then sample.
  - rx_sync=1: good frame, go directly to IDLE. Leaving at mid-stop-bit gives half-bit margin for the next start.
  - rx_sync=0: frame_err_o pulses on the next cycle, the byte is discarded, go to BREAK.
- BREAK: stay until rx_sync=1, then go to IDLE. A held-low line must not retrigger START.

Output holding register:
- On a good-frame sample edge:
  - If valid_out=0, or valid_out & ready_out in that same cycle: data_o <= shift register and valid_out <= 1. A simultaneous pop and load leaves valid_out high with the new data.
  - Otherwise: data_o is unchanged and overrun_o pulses for exactly one cycle.
- Without a load: valid_out & ready_out clears valid_out on the next edge.
- data_o is stable while valid_out=1 and the byte is not accepted.
- ready_out is ignored while valid_out=0.

Latency:
- Edge 1 is the first edge sampling rx_i=0.
- rx_sync goes low after edge 2; START is entered at edge 3.
- Data bit i is sampled at edge 3 + H + (i+1)*CLKS_PER_BIT.
- The stop bit is sampled, and valid_out rises, at edge 3 + H + (DATA_WIDTH+1)*CLKS_PER_BIT.

Flags:
- frame_err_o and overrun_o are registered.
- Each is high for exactly one cycle per event and is never asserted together with a load.

Test Plan:
1. CLKS_PER_BIT=16, ready_out=1, send 0xA5 -> valid_out rises at edge 155; data_o=0xA5; valid_out high for 1 cycle; no flags.
2. ready_out=0, send 0x3C then 0xC3 back-to-back -> data_o holds 0x3C; overrun_o pulses once at 0xC3's stop sample; raising ready_out pops 0x3C and valid_out drops.
3. Send 0xFF with the stop bit forced low for 40 cycles -> frame_err_o single pulse, valid_out stays 0, busy_o high until the line returns high; a following 0x55 is received correctly.
4. rx_i low for 4 cycles only -> FSM returns to IDLE at edge 3+H; no valid_out, no flags.
5. rstn=0 for one edge during data bit 3 of 0x81 -> all outputs 0 next cycle; a subsequent clean 0x81 frame yields data_o=0x81.
6. Holding 0x11 with ready_out=0; raise ready_out exactly on the stop-sample edge of 0x22 -> valid_out stays 1, data_o=0x22, no overrun_o.
